// File: rtl/keypad_reader.sv
// keypad_reader: scans a 4x4 active-low keypad, debounces presses and shifts digits into m/c/d/u.
// Optional feature macro: KEYPAD_BACKSPACE_EN makes 'D' delete the most recent digit.
module keypad_reader #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] m,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] u,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       enter
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_DONE   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_COMMIT, S_RELEASE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cols_q;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       rows_meta_q, rs_q;
  logic [3:0]       m_q, m_d, c_q, c_d, d_q, d_d, u_q, u_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             enter_q, enter_d;
  logic [3:0]       commit_key;

  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] v;
    v = ~r;
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] p);
    case (p)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] ci);
    case ({r, ci})
      4'h0: return 4'd1;
      4'h1: return 4'd2;
      4'h2: return 4'd3;
      4'h3: return 4'd10;
      4'h4: return 4'd4;
      4'h5: return 4'd5;
      4'h6: return 4'd6;
      4'h7: return 4'd11;
      4'h8: return 4'd7;
      4'h9: return 4'd8;
      4'hA: return 4'd9;
      4'hB: return 4'd12;
      4'hC: return KEY_STAR;
      4'hD: return 4'd0;
      4'hE: return KEY_HASH;
      default: return KEY_D;
    endcase
  endfunction

  // The column stays held from capture through release, so col_q identifies the key.
  assign commit_key = key_lookup(row_of(pat_q), col_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    pat_d       = pat_q;
    m_d         = m_q;
    c_d         = c_q;
    d_d         = d_q;
    u_d         = u_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    enter_d     = 1'b0;

    case (state_q)
      S_SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (one_low(rs_q)) begin
            pat_d   = rs_q;
            cnt_d   = CNT_W'(1);
            state_d = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (rs_q != pat_q) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else if (cnt_q >= DEB_DONE) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        key_valid_d = 1'b1;
        key_code_d  = commit_key;
        state_d     = S_RELEASE;
        cnt_d       = '0;
        if (commit_key <= 4'd9) begin
          m_d = c_q;
          c_d = d_q;
          d_d = u_q;
          u_d = commit_key;
        end else if (commit_key == KEY_STAR) begin
          m_d = 4'd0;
          c_d = 4'd0;
          d_d = 4'd0;
          u_d = 4'd0;
        end else if (commit_key == KEY_HASH) begin
          enter_d = 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
        end else if (commit_key == KEY_D) begin
          u_d = d_q;
          d_d = c_q;
          c_d = m_q;
          m_d = 4'd0;
`endif
        end
      end
      S_RELEASE: begin
        if (rs_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_SCAN;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      cols_q      <= 4'b0111;
      pat_q       <= 4'hF;
      rows_meta_q <= 4'hF;
      rs_q        <= 4'hF;
      m_q         <= 4'd0;
      c_q         <= 4'd0;
      d_q         <= 4'd0;
      u_q         <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      enter_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      cols_q      <= ~(4'b1000 >> col_d);
      pat_q       <= pat_d;
      rows_meta_q <= rows;
      rs_q        <= rows_meta_q;
      m_q         <= m_d;
      c_q         <= c_d;
      d_q         <= d_d;
      u_q         <= u_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      enter_q     <= enter_d;
    end
  end

  assign cols      = cols_q;
  assign m         = m_q;
  assign c         = c_q;
  assign d         = d_q;
  assign u         = u_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign enter     = enter_q;

endmodule

// File: tb/tb_keypad_reader.sv
// Bench for keypad_reader: keypad model driven by a vector table, scoreboard checked on key_valid.
module tb_keypad_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows, cols, m, c, d, u, key_code;
  logic       key_valid, enter;
  logic [15:0] pressed = '0;

  int checks   = 0;
  int failures = 0;
  int kv_count = 0;
  logic kv_prev = 1'b0;

  typedef struct {
    logic [3:0] code;
    logic [3:0] m, c, d, u;
    logic       enter;
  } exp_t;

  typedef struct {
    logic [3:0] key;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  // Key codes laid out as [row*4 + col]
  logic [3:0] keymap [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                              4'd4, 4'd5, 4'd6, 4'd11,
                              4'd7, 4'd8, 4'd9, 4'd12,
                              4'd14, 4'd0, 4'd15, 4'd13};

  always #5 clock = ~clock;

  keypad_reader dut (
    .clock(clock), .reset(reset), .rows(rows), .cols(cols),
    .m(m), .c(c), .d(d), .u(u),
    .key_code(key_code), .key_valid(key_valid), .enter(enter)
  );

  // Membrane model: a pressed key shorts its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int ci = 0; ci < 4; ci++)
        if (pressed[r*4+ci] && !cols[3-ci]) rows[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pos_of(input logic [3:0] key);
    for (int i = 0; i < 16; i++) if (keymap[i] == key) return i;
    return 0;
  endfunction

  function automatic vec_t mk(input logic [3:0] key, input logic [3:0] code,
                              input logic [3:0] em, input logic [3:0] ec,
                              input logic [3:0] ed, input logic [3:0] eu, input logic en);
    vec_t v;
    v.key = key;
    v.exp.code = code;
    v.exp.m = em; v.exp.c = ec; v.exp.d = ed; v.exp.u = eu;
    v.exp.enter = en;
    return v;
  endfunction

  task automatic press(input logic [3:0] key, input int hold, input int rel);
    pressed = 16'(1) << pos_of(key);
    repeat (hold) @(negedge clock);
    pressed = '0;
    repeat (rel) @(negedge clock);
  endtask

  task automatic chk_digits(input string name, input logic [3:0] em, input logic [3:0] ec,
                            input logic [3:0] ed, input logic [3:0] eu);
    chk({name, "_m"}, int'(m), int'(em));
    chk({name, "_c"}, int'(c), int'(ec));
    chk({name, "_d"}, int'(d), int'(ed));
    chk({name, "_u"}, int'(u), int'(eu));
  endtask

  // Scoreboard monitor: every key_valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    chk("enter_without_valid", int'(enter & ~key_valid), 0);
    chk("key_valid_width", int'(key_valid & kv_prev), 0);
    kv_prev = key_valid;
    if (key_valid) begin
      kv_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key_valid: key_code=%0d with no press outstanding", key_code);
      end else begin
        e = sb.pop_front();
        chk("key_code", int'(key_code), int'(e.code));
        chk("enter_pulse", int'(enter), int'(e.enter));
        chk_digits("commit", e.m, e.c, e.d, e.u);
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [3:0] exp_cols;
    logic [3:0] prev_cols;
    int n, trans, kv_before;

    vecs.push_back(mk(4'd1,  4'd1,  4'd0, 4'd0, 4'd0, 4'd1, 1'b0));
    vecs.push_back(mk(4'd2,  4'd2,  4'd0, 4'd0, 4'd1, 4'd2, 1'b0));
    vecs.push_back(mk(4'd3,  4'd3,  4'd0, 4'd1, 4'd2, 4'd3, 1'b0));
    vecs.push_back(mk(4'd4,  4'd4,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
    vecs.push_back(mk(4'd5,  4'd5,  4'd2, 4'd3, 4'd4, 4'd5, 1'b0));
    vecs.push_back(mk(4'd15, 4'd15, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1));
    vecs.push_back(mk(4'd14, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    vecs.push_back(mk(4'd1,  4'd1,  4'd0, 4'd0, 4'd0, 4'd1, 1'b0));
    vecs.push_back(mk(4'd2,  4'd2,  4'd0, 4'd0, 4'd1, 4'd2, 1'b0));
    vecs.push_back(mk(4'd3,  4'd3,  4'd0, 4'd1, 4'd2, 4'd3, 1'b0));
    vecs.push_back(mk(4'd4,  4'd4,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
`ifdef KEYPAD_BACKSPACE_EN
    vecs.push_back(mk(4'd13, 4'd13, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0));
    vecs.push_back(mk(4'd10, 4'd10, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0));
`else
    vecs.push_back(mk(4'd13, 4'd13, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
    vecs.push_back(mk(4'd10, 4'd10, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
`endif

    // Reset values
    repeat (3) @(negedge clock);
    chk("reset_cols", int'(cols), 7);
    chk_digits("reset", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset_key_code", int'(key_code), 0);
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_enter", int'(enter), 0);
    reset = 1'b0;

    // Idle scan: one column step every SCAN_DIV clocks
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      exp_cols = ~(4'b1000 >> ((k / 4) % 4));
      chk($sformatf("idle_cols_%0d", k), int'(cols), int'(exp_cols));
    end
    chk_digits("idle", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("idle_no_pulse", kv_count, 0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].exp);
      press(vecs[i].key, 40, 40);
      chk($sformatf("pulse_seen_%0d", i), sb.size(), 0);
      sb.delete();
      chk_digits($sformatf("steady_%0d", i), vecs[i].exp.m, vecs[i].exp.c,
                 vecs[i].exp.d, vecs[i].exp.u);
    end
    chk("table_pulse_count", kv_count, vecs.size());

    // Bouncing '7' never stays low long enough to commit
    kv_before = kv_count;
    for (int i = 0; i < 8; i++) begin
      pressed = 16'(1) << pos_of(4'd7);
      repeat (2) @(negedge clock);
      pressed = '0;
      repeat (10) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    chk("bounce_no_commit", kv_count - kv_before, 0);

    // Clean hold of '7' commits exactly once
`ifdef KEYPAD_BACKSPACE_EN
    sb.push_back(mk(4'd7, 4'd7, 4'd1, 4'd2, 4'd3, 4'd7, 1'b0).exp);
`else
    sb.push_back(mk(4'd7, 4'd7, 4'd2, 4'd3, 4'd4, 4'd7, 1'b0).exp);
`endif
    press(4'd7, 40, 40);
    chk("hold7_pulse_seen", sb.size(), 0);
    sb.delete();
    chk("hold7_single_pulse", kv_count - kv_before, 1);

    // Two rows low on col0 ('1' and '4'): rejected, scanning keeps rotating
    kv_before = kv_count;
    pressed = 16'(1) << pos_of(4'd1);
    pressed = pressed | (16'(1) << pos_of(4'd4));
    prev_cols = cols;
    trans = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (cols != prev_cols) trans++;
      prev_cols = cols;
    end
    pressed = '0;
    repeat (30) @(negedge clock);
    chk("ghost_scan_continues", int'(trans >= 14), 1);
    chk("ghost_no_commit", kv_count - kv_before, 0);

    // Reset while '9' is being debounced
    n = 0;
    while (cols != 4'b1110 && n < 40) begin @(negedge clock); n++; end
    pressed = 16'(1) << pos_of(4'd9);
    n = 0;
    while (cols != 4'b1101 && n < 40) begin @(negedge clock); n++; end
    chk("col2_reached", int'(cols == 4'b1101), 1);
    repeat (4) @(negedge clock);
    chk("held_in_debounce", int'(cols), int'(4'b1101));
    kv_before = kv_count;
    reset = 1'b1;
    #1;
    chk("async_reset_cols", int'(cols), 7);
    chk_digits("async_reset", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("async_reset_key_code", int'(key_code), 0);
    chk("async_reset_key_valid", int'(key_valid), 0);
    pressed = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("post_reset_no_commit", kv_count - kv_before, 0);
    chk_digits("post_reset", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_reader.md
Name: keypad_reader

Overview:
- Scans a 4x4 membrane keypad and debounces key presses.
- Decodes each press and shifts digits into four BCD registers m, c, d, u. These are the keypad-side digit inputs consumed by the 7-segment display block.
- Column strobing uses the same one-hot-low rotation as the display multiplexer.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven before rows are sampled; must be >= 4.
- DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release; must be >= 1.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- rows  input  4  keypad row lines, active-low, asynchronous to clock.
- cols  output  4  keypad column drive, active-low, exactly one bit low at a time.
- m  output  4  thousands BCD digit.
- c  output  4  hundreds BCD digit.
- d  output  4  tens BCD digit.
- u  output  4  units BCD digit.
- key_code  output  4  code of the last committed key.
- key_valid  output  1  one-cycle pulse when a key is committed.
- enter  output  1  one-cycle pulse when '#' is committed.

Behaviour:
- Reset values: cols=4'b0111, m=c=d=u=0, key_code=0, key_valid=0, enter=0, FSM=SCAN, all counters 0.
- rows pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rs).
- Column sequence: 0111 -> 1011 -> 1101 -> 1110 -> 0111, mapping to col index 0..3.
- Keymap [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- key_code encoding: digits 0-9 as value; A=10, B=11, C=12, D=13, *=14, #=15.
- FSM states: SCAN, DEBOUNCE, COMMIT, RELEASE.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1 on the current column; the sample is taken on the last dwell cycle.
  - Exactly one rs bit low at the sample: capture the row pattern, go to DEBOUNCE, counter=1, cols held.
  - rs all high, or two or more bits low (ghost/multi-key): advance to the next column and restart the dwell.
- DEBOUNCE:
  - Each cycle, rs equal to the captured pattern increments the counter.
  - On a mismatch, return to SCAN on the next column with no output change.
  - When counter reaches DEBOUNCE_CYCLES, go to COMMIT.
- COMMIT (exactly one cycle). Outputs below are registered and visible the cycle after COMMIT:
  - key_valid=1 and key_code updated.
  - Digit key k: m<=c, c<=d, d<=u, u<=k (shift-left entry; oldest digit discarded).
  - '*': m=c=d=u=0.
  - '#': enter=1; digits unchanged.
  - A, B, C: key_valid and key_code only, digits unchanged (D: see optional feature).
  - Then go to RELEASE.
- RELEASE:
  - cols held on the pressed column.
  - The counter increments while rs==4'b1111 and resets to 0 on any low bit.
  - At DEBOUNCE_CYCLES, go to SCAN starting at the next column.
  - A held key therefore commits exactly once.
- Latency: with a clean press stable from the sample edge, key_valid rises DEBOUNCE_CYCLES+1 edges after the sample edge.
- key_valid and enter are never high for more than one cycle, and never high outside the cycle after COMMIT.
- Reset asserted in any state returns to reset values immediately (asynchronously); no partial commit occurs.
- Digits are only ever loaded with 0-9, so m/c/d/u always hold valid BCD.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: 'D' in COMMIT performs backspace: u<=d, d<=c, c<=m, m<=0; key_valid pulses with key_code=13.
- Undefined: 'D' behaves like A-C (key_valid/key_code only, digits unchanged).

Test Plan:
- Reset, rows=4'b1111 for 100 cycles -> cols rotates 0111,1011,1101,1110 every 4 clocks; m=c=d=u=0; no key_valid.
- Press '1','2','3','4', then '5', each held 40 cycles and released 40 cycles -> after the fourth press m,c,d,u=1,2,3,4; after '5' they are 2,3,4,5; exactly 5 key_valid pulses.
- With digits 2,3,4,5, press '#' -> one enter pulse, key_code=15, digits unchanged; then press '*' -> digits 0,0,0,0, key_code=14.
- Bounce: '7' low for 2 cycles then high for 10, repeated -> no key_valid. Hold '7' for 40 cycles -> exactly one key_valid, u=7.
- Rows 0 and 1 low simultaneously on col0 -> no commit, scanning continues. Assert reset during DEBOUNCE of '9' -> outputs at reset values, no key_valid.
- With KEYPAD_BACKSPACE_EN and digits 1,2,3,4, press 'D' -> digits 0,1,2,3. Without the macro -> digits stay 1,2,3,4, key_code=13.
